// File: rtl/wave_reader.sv
// Capture-buffer reader: fetches DEPTH samples through a sync-read port and streams them as screen points.
// Optional macro WAVE_READER_MINMAX_EN adds fr_min/fr_max of the last completed frame.
module wave_reader #(
    parameter int DATA_W      = 12,
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int Y_W         = 10,
    parameter int Y_BASE      = 700,
    parameter int SCALE_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_done,
    output logic              cap_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] pt_x,
    output logic [Y_W-1:0]    pt_y,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic              frame_done
`ifdef WAVE_READER_MINMAX_EN
    ,
    output logic [DATA_W-1:0] fr_min,
    output logic [DATA_W-1:0] fr_max
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Comparison width wide enough for both the shifted sample and Y_BASE, so the clamp never wraps.
    localparam int              CW       = (DATA_W > Y_W + 1) ? DATA_W : Y_W + 1;
    localparam logic [CW-1:0]   Y_BASE_C = CW'(Y_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1'b1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              cap_ready_q, cap_ready_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              pt_valid_q, pt_valid_d;
    logic [ADDR_W-1:0] pt_x_q, pt_x_d;
    logic [Y_W-1:0]    pt_y_q, pt_y_d;
    logic              frame_done_q, frame_done_d;
    logic [CW-1:0]     s_s;
    logic [Y_W-1:0]    y_map_s;

    // Sample-to-screen mapping with clamp at the top of the trace area.
    always_comb begin
        s_s = CW'(rd_data >> SCALE_SHIFT);
        if (s_s <= Y_BASE_C) begin
            y_map_s = Y_W'(Y_BASE_C - s_s);
        end else begin
            y_map_s = {Y_W{1'b0}};
        end
    end

    // Frame readout sequencing: fetch, wait for sync-read data, present until accepted.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cap_ready_d  = cap_ready_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        pt_valid_d   = pt_valid_q;
        pt_x_d       = pt_x_q;
        pt_y_d       = pt_y_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cap_done) begin
                    cap_ready_d = 1'b0;
                    idx_d       = {ADDR_W{1'b0}};
                    rd_en_d     = 1'b1;
                    rd_addr_d   = {ADDR_W{1'b0}};
                    state_d     = S_FETCH;
                end else begin
                    cap_ready_d = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                pt_x_d     = idx_q;
                pt_y_d     = y_map_s;
                pt_valid_d = 1'b1;
                state_d    = S_PRESENT;
            end
            S_PRESENT: begin
                if (pt_ready) begin
                    pt_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        idx_d     = idx_q + ONE_IDX;
                        rd_en_d   = 1'b1;
                        rd_addr_d = idx_q + ONE_IDX;
                        state_d   = S_FETCH;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_DONE: begin
                cap_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                cap_ready_d = 1'b1;
                pt_valid_d  = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= {ADDR_W{1'b0}};
            cap_ready_q  <= 1'b1;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= {ADDR_W{1'b0}};
            pt_valid_q   <= 1'b0;
            pt_x_q       <= {ADDR_W{1'b0}};
            pt_y_q       <= {Y_W{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cap_ready_q  <= cap_ready_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            pt_valid_q   <= pt_valid_d;
            pt_x_q       <= pt_x_d;
            pt_y_q       <= pt_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cap_ready  = cap_ready_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign pt_valid   = pt_valid_q;
    assign pt_x       = pt_x_q;
    assign pt_y       = pt_y_q;
    assign frame_done = frame_done_q;

`ifdef WAVE_READER_MINMAX_EN
    logic [DATA_W-1:0] run_min_q, run_min_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] fr_min_q, fr_min_d;
    logic [DATA_W-1:0] fr_max_q, fr_max_d;

    // Running extremes over the frame; published when the frame completes.
    always_comb begin
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        fr_min_d  = fr_min_q;
        fr_max_d  = fr_max_q;
        if (state_q == S_IDLE && cap_done) begin
            run_min_d = {DATA_W{1'b1}};
            run_max_d = {DATA_W{1'b0}};
        end else if (state_q == S_WAIT) begin
            if (rd_data < run_min_q) begin
                run_min_d = rd_data;
            end else begin
                run_min_d = run_min_q;
            end
            if (rd_data > run_max_q) begin
                run_max_d = rd_data;
            end else begin
                run_max_d = run_max_q;
            end
        end else if (frame_done_d) begin
            fr_min_d = run_min_q;
            fr_max_d = run_max_q;
        end else begin
            fr_min_d = fr_min_q;
        end
    end

    // Min/max registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_min_q <= {DATA_W{1'b0}};
            run_max_q <= {DATA_W{1'b0}};
            fr_min_q  <= {DATA_W{1'b0}};
            fr_max_q  <= {DATA_W{1'b0}};
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            fr_min_q  <= fr_min_d;
            fr_max_q  <= fr_max_d;
        end
    end

    assign fr_min = fr_min_q;
    assign fr_max = fr_max_q;
`endif

endmodule

// File: tb/tb_wave_reader.sv
// Randomised bench for wave_reader: two instances (Y_BASE 700 and 100) checked against a point-level reference model.
module tb_wave_reader;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int Y_W    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, cap_done, pt_ready;
    logic              a_cap_ready, a_rd_en, a_pt_valid, a_frame_done;
    logic [ADDR_W-1:0] a_rd_addr, a_pt_x;
    logic [Y_W-1:0]    a_pt_y;
    logic [DATA_W-1:0] a_rd_data;
    logic              b_cap_ready, b_rd_en, b_pt_valid, b_frame_done;
    logic [ADDR_W-1:0] b_rd_addr, b_pt_x;
    logic [Y_W-1:0]    b_pt_y;
    logic [DATA_W-1:0] b_rd_data;
`ifdef WAVE_READER_MINMAX_EN
    logic [DATA_W-1:0] a_fr_min, a_fr_max, b_fr_min, b_fr_max;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    int  n_pass = 0;
    int  n_checks = 0;
    int  a_idx = 0;
    int  b_idx = 0;
    int  lat = 0;
    int  frames_a = 0;
    bit  bp_mode = 1'b0;
    bit  full_rate = 1'b1;

    wave_reader #(.Y_BASE(700)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cap_done(cap_done), .cap_ready(a_cap_ready),
        .rd_addr(a_rd_addr), .rd_en(a_rd_en), .rd_data(a_rd_data),
        .pt_x(a_pt_x), .pt_y(a_pt_y), .pt_valid(a_pt_valid), .pt_ready(pt_ready),
        .frame_done(a_frame_done)
`ifdef WAVE_READER_MINMAX_EN
        , .fr_min(a_fr_min), .fr_max(a_fr_max)
`endif
    );

    wave_reader #(.Y_BASE(100)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cap_done(cap_done), .cap_ready(b_cap_ready),
        .rd_addr(b_rd_addr), .rd_en(b_rd_en), .rd_data(b_rd_data),
        .pt_x(b_pt_x), .pt_y(b_pt_y), .pt_valid(b_pt_valid), .pt_ready(pt_ready),
        .frame_done(b_frame_done)
`ifdef WAVE_READER_MINMAX_EN
        , .fr_min(b_fr_min), .fr_max(b_fr_max)
`endif
    );

    // Synchronous-read capture buffers, one per instance.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= mem[b_rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int y_model(input int sample, input int base);
        int s;
        s = sample / 8;
        return (s <= base) ? (base - s) : 0;
    endfunction

    function automatic int exp_y(input int idx, input int base);
        return (idx < DEPTH) ? y_model(int'(mem[idx]), base) : -1;
    endfunction

    // Plotter-side backpressure.
    initial begin
        pt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            pt_ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Point scoreboard and handshake checker, sampled on the falling edge.
    initial begin
        bit              hold;
        bit              prev_cr;
        logic [ADDR_W-1:0] hold_x;
        logic [Y_W-1:0]    hold_y;
        hold = 1'b0;
        prev_cr = 1'b1;
        hold_x = '0;
        hold_y = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_idx = 0; b_idx = 0; hold = 1'b0; prev_cr = 1'b1; lat = 0;
            end else begin
                if (prev_cr && !a_cap_ready) lat = 0;
                else lat++;
                prev_cr = a_cap_ready;
                if (hold) begin
                    check_eq("hold_valid", 32'(a_pt_valid), 32'd1);
                    check_eq("hold_x", 32'(a_pt_x), 32'(hold_x));
                    check_eq("hold_y", 32'(a_pt_y), 32'(hold_y));
                end
                if (a_rd_en) check_eq("rd_addr", 32'(a_rd_addr), 32'(a_idx));
                if (a_pt_valid && pt_ready) begin
                    check_eq("a_x", 32'(a_pt_x), 32'(a_idx));
                    check_eq("a_y", 32'(a_pt_y), 32'(exp_y(a_idx, 700)));
                    a_idx++;
                end
                hold   = a_pt_valid && !pt_ready;
                hold_x = a_pt_x;
                hold_y = a_pt_y;
                if (b_pt_valid && pt_ready) begin
                    check_eq("b_x", 32'(b_pt_x), 32'(b_idx));
                    check_eq("b_y", 32'(b_pt_y), 32'(exp_y(b_idx, 100)));
                    b_idx++;
                end
                if (a_frame_done) begin
                    check_eq("a_frame_len", 32'(a_idx), 32'(DEPTH));
                    if (full_rate) check_eq("frame_lat", 32'(lat), 32'(3 * DEPTH));
                    a_idx = 0;
                    frames_a++;
                end
                if (b_frame_done) begin
                    check_eq("b_frame_len", 32'(b_idx), 32'(DEPTH));
                    b_idx = 0;
                end
            end
        end
    end

    task automatic run_frame(input int budget, input bit drop_early);
        bit seen;
        seen = 1'b0;
        cap_done = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (drop_early && c == 10) cap_done = 1'b0;
            if (a_frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        cap_done = 1'b0;
        if (!seen) check_eq("frame_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        check_eq("cap_ready_after", 32'(a_cap_ready), 32'd1);
        check_eq("idle_no_valid", 32'(a_pt_valid), 32'd0);
`ifdef WAVE_READER_MINMAX_EN
        begin
            int mn, mx;
            mn = 4095; mx = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(mem[i]) < mn) mn = int'(mem[i]);
                if (int'(mem[i]) > mx) mx = int'(mem[i]);
            end
            check_eq("fr_min", 32'(a_fr_min), 32'(mn));
            check_eq("fr_max", 32'(a_fr_max), 32'(mx));
        end
`endif
    endtask

    task automatic check_reset_state();
        check_eq("rst_cap_ready", 32'(a_cap_ready), 32'd1);
        check_eq("rst_pt_valid", 32'(a_pt_valid), 32'd0);
        check_eq("rst_rd_en", 32'(a_rd_en), 32'd0);
        check_eq("rst_frame_done", 32'(a_frame_done), 32'd0);
        check_eq("rst_pt_x", 32'(a_pt_x), 32'd0);
        check_eq("rst_pt_y", 32'(a_pt_y), 32'd0);
        check_eq("rst_rd_addr", 32'(a_rd_addr), 32'd0);
    endtask

    initial begin
        int frames_before;
        rst_n = 1'b0;
        cap_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i * 8);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        // Ramp: point k lands at y = 700-k (and clamps to 0 on the Y_BASE=100 instance).
        run_frame(4000, 1'b0);

        for (int i = 0; i < DEPTH; i++) mem[i] = 12'hFFF;
        run_frame(4000, 1'b0);

        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(5 + (i * 995) / (DEPTH - 1));
        run_frame(4000, 1'b0);

        // Random samples under heavy backpressure, cap_done dropped mid-frame.
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 4095));
        bp_mode = 1'b1;
        full_rate = 1'b0;
        run_frame(20000, 1'b1);
        bp_mode = 1'b0;
        full_rate = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Abort a frame at point 200 with reset, then restart from address 0.
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 4095));
        frames_before = frames_a;
        cap_done = 1'b1;
        for (int c = 0; c < 2000 && a_idx < 200; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("reached_pt200", 32'(a_idx >= 200), 32'd1);
        rst_n = 1'b0;
        cap_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        check_eq("abort_no_frame_done", 32'(frames_a), 32'(frames_before));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(4000, 1'b0);
        check_eq("restart_frame_done", 32'(frames_a), 32'(frames_before + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
